// File: rtl/display_mode_sequencer.sv
// Video mode switch sequencer: blanks the display, reprograms the pixel clock
// generator over DRP from a per-mode ROM table, waits for lock and settle, then unblanks.
module display_mode_sequencer #(
    parameter int MODE_W        = 2,
    parameter int REG_W         = 5,
    parameter int REG_COUNT     = 23,
    parameter int DEFAULT_MODE  = 0,
    parameter int BLANK_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int DRP_TIMEOUT   = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req,
    input  logic [MODE_W-1:0]       i_req_mode,
    output logic                    o_ack,
    output logic                    o_busy,
    output logic                    o_err,
    output logic [MODE_W-1:0]       o_mode,
    output logic [MODE_W+REG_W-1:0] o_rom_addr,
    input  logic [22:0]             i_rom_data,
    output logic                    o_drp_en,
    output logic                    o_drp_we,
    output logic [6:0]              o_drp_addr,
    output logic [15:0]             o_drp_di,
    input  logic                    i_drp_rdy,
    input  logic                    i_locked,
    output logic                    o_clk_rst,
    output logic                    o_timing_rst,
    output logic                    o_blank
);

    localparam int MAX_AB = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CD = (LOCK_TIMEOUT > DRP_TIMEOUT) ? LOCK_TIMEOUT : DRP_TIMEOUT;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_BLANK, S_FETCH, S_WRITE, S_WAIT_RDY,
        S_RELEASE, S_LOCK, S_SETTLE, S_UNBLANK, S_FAIL
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [REG_W-1:0]   reg_idx_r;
    logic               lock_meta_r;
    logic               lock_sync_r;

    // Two-flop synchroniser for the asynchronous lock indication
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= i_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= S_BLANK;
            cnt_r        <= '0;
            reg_idx_r    <= '0;
            o_ack        <= 1'b0;
            o_busy       <= 1'b1;
            o_err        <= 1'b0;
            o_mode       <= MODE_W'(DEFAULT_MODE);
            o_rom_addr   <= '0;
            o_drp_en     <= 1'b0;
            o_drp_we     <= 1'b0;
            o_drp_addr   <= 7'd0;
            o_drp_di     <= 16'd0;
            o_clk_rst    <= 1'b1;
            o_timing_rst <= 1'b1;
            o_blank      <= 1'b1;
        end else begin
            o_ack    <= 1'b0;
            o_drp_en <= 1'b0;
            o_drp_we <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // Losing lock while running takes priority over any request
                    if (!lock_sync_r) begin
                        o_blank      <= 1'b1;
                        o_timing_rst <= 1'b1;
                        o_busy       <= 1'b1;
                        cnt_r        <= '0;
                        state_r      <= S_LOCK;
                    end else if (i_req) begin
                        o_ack <= 1'b1;
                        if (i_req_mode != o_mode) begin
                            o_mode  <= i_req_mode;
                            o_err   <= 1'b0;
                            o_blank <= 1'b1;
                            o_busy  <= 1'b1;
                            cnt_r   <= '0;
                            state_r <= S_BLANK;
                        end
                    end
                end
                S_BLANK: begin
                    if (cnt_r == CNT_W'(BLANK_CYCLES - 1)) begin
                        o_clk_rst    <= 1'b1;
                        o_timing_rst <= 1'b1;
                        reg_idx_r    <= '0;
                        o_rom_addr   <= {o_mode, REG_W'(0)};
                        state_r      <= S_FETCH;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_FETCH: begin
                    state_r <= S_WRITE;
                end
                S_WRITE: begin
                    o_drp_en   <= 1'b1;
                    o_drp_we   <= 1'b1;
                    o_drp_addr <= i_rom_data[22:16];
                    o_drp_di   <= i_rom_data[15:0];
                    cnt_r      <= '0;
                    state_r    <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (i_drp_rdy) begin
                        if (reg_idx_r == REG_W'(REG_COUNT - 1)) begin
                            state_r <= S_RELEASE;
                        end else begin
                            reg_idx_r  <= reg_idx_r + REG_W'(1);
                            o_rom_addr <= {o_mode, reg_idx_r + REG_W'(1)};
                            state_r    <= S_FETCH;
                        end
                    end else if (cnt_r == CNT_W'(DRP_TIMEOUT - 1)) begin
                        o_err        <= 1'b1;
                        o_busy       <= 1'b0;
                        o_clk_rst    <= 1'b1;
                        o_timing_rst <= 1'b1;
                        o_blank      <= 1'b1;
                        state_r      <= S_FAIL;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    o_clk_rst <= 1'b0;
                    cnt_r     <= '0;
                    state_r   <= S_LOCK;
                end
                S_LOCK: begin
                    if (lock_sync_r) begin
                        cnt_r   <= '0;
                        state_r <= S_SETTLE;
                    end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        o_err        <= 1'b1;
                        o_busy       <= 1'b0;
                        o_clk_rst    <= 1'b1;
                        o_timing_rst <= 1'b1;
                        o_blank      <= 1'b1;
                        state_r      <= S_FAIL;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (!lock_sync_r) begin
                        cnt_r   <= '0;
                        state_r <= S_LOCK;
                    end else if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
                        o_timing_rst <= 1'b0;
                        state_r      <= S_UNBLANK;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_UNBLANK: begin
                    o_blank <= 1'b0;
                    o_busy  <= 1'b0;
                    state_r <= S_IDLE;
                end
                S_FAIL: begin
                    // Any request, even for the current mode, reruns the full sequence
                    if (i_req) begin
                        o_ack   <= 1'b1;
                        o_mode  <= i_req_mode;
                        o_err   <= 1'b0;
                        o_busy  <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= S_BLANK;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    o_err        <= 1'b1;
                    o_busy       <= 1'b0;
                    o_clk_rst    <= 1'b1;
                    o_timing_rst <= 1'b1;
                    o_blank      <= 1'b1;
                    state_r      <= S_FAIL;
                end
            endcase
        end
    end

endmodule
